mem_access_ctrl: RTL and testbench

- Upstream front-end for the 32x4 memory block on the DE-series board.
- Converts the raw, bouncy KEY pushbutton into clean single-cycle write strobes, and registers the switch address and data into the memory's ports.
- Provides an auto-scan mode that steps through all addresses so stored contents can be viewed on the HEX displays.
- The memory is clocked by the system clock; writes are qualified by this block's strobe.

---
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Pushbutton/switch front-end for the 32x4 board memory: debounced single-shot writes plus a timed address scan.
// All outputs registered; press is seen DEBOUNCE_CYCLES+2 cycles after key_n settles low.
module mem_access_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_PERIOD     = 50000000,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_we,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              scan_active
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(SCAN_PERIOD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_REL, S_SCAN, S_SCAN_PAUSE
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              vld1_q, vld1_d, vld2_q, vld2_d;
  logic              arm_q, arm_d;
  logic              deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_q, press_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              scan_active_q, scan_active_d;
  logic              differ;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    // A key held through reset must be seen released before it can press.
    arm_d   = arm_q | (vld2_q & sync2_q);
    differ  = (sync2_q != deb_q);
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (differ) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d   = ~deb_q;
        press_d = deb_q & arm_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    state_d    = state_q;
    timer_d    = timer_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_en) begin
          state_d = S_SCAN;
          timer_d = '0;
        end else if (press_q && sw_we) begin
          state_d  = S_WRITE;
          mem_we_d = 1'b1;
        end else if (press_q) begin
          state_d = S_WAIT_REL;
        end else begin
          mem_addr_d = sw_addr;
          mem_din_d  = sw_data;
        end
      end
      S_WRITE:    state_d = S_WAIT_REL;
      S_WAIT_REL: if (deb_q) state_d = S_IDLE;
      S_SCAN: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (press_q) begin
          state_d = S_SCAN_PAUSE;
        end else if (timer_q == TMR_W'(SCAN_PERIOD - 1)) begin
          timer_d    = '0;
          mem_addr_d = mem_addr_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SCAN_PAUSE: begin
        if (!scan_en)     state_d = S_IDLE;
        else if (press_q) state_d = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d        = (state_d == S_WRITE) || (state_d == S_WAIT_REL);
    scan_active_d = (state_d == S_SCAN) || (state_d == S_SCAN_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      vld1_q        <= 1'b0;
      vld2_q        <= 1'b0;
      arm_q         <= 1'b0;
      deb_q         <= 1'b1;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      timer_q       <= '0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      scan_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      vld1_q        <= vld1_d;
      vld2_q        <= vld2_d;
      arm_q         <= arm_d;
      deb_q         <= deb_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      timer_q       <= timer_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      scan_active_q <= scan_active_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign scan_active = scan_active_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle comparison against a behavioural model plus hand-computed spot checks.
module tb_mem_access_ctrl;
  localparam int D = 4;
  localparam int P = 8;
  localparam int M_IDLE = 0, M_WRITE = 1, M_WAITR = 2, M_SCAN = 3, M_PAUSE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [4:0] sw_addr = '0;
  logic [3:0] sw_data = '0;
  logic       sw_we = 1'b0;
  logic       scan_en = 1'b0;
  logic [4:0] mem_addr;
  logic [3:0] mem_din;
  logic       mem_we, busy, scan_active;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DEBOUNCE_CYCLES(D), .SCAN_PERIOD(P), .ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_addr(sw_addr), .sw_data(sw_data),
    .sw_we(sw_we), .scan_en(scan_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .busy(busy), .scan_active(scan_active)
  );

  int vec = 0;
  int mis = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: key history, run-length debounce, mode rules.
  int m_mode = M_IDLE;
  int m_addr = 0, m_din = 0, m_timer = 0, m_run = 0;
  bit m_we = 0, m_deb = 1, m_press_p = 0, m_armed = 0;
  bit hist[$];
  bit kd, kvalid, press_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_addr = 0; m_din = 0; m_timer = 0; m_run = 0;
      m_we = 0; m_deb = 1; m_press_p = 0; m_armed = 0;
      hist.delete();
    end else begin
      case (m_mode)
        M_IDLE:
          if (scan_en) begin m_mode = M_SCAN; m_timer = 0; end
          else if (m_press_p && sw_we) m_mode = M_WRITE;
          else if (m_press_p) m_mode = M_WAITR;
          else begin m_addr = sw_addr; m_din = sw_data; end
        M_WRITE: m_mode = M_WAITR;
        M_WAITR: if (m_deb) m_mode = M_IDLE;
        M_SCAN:
          if (!scan_en) m_mode = M_IDLE;
          else if (m_press_p) m_mode = M_PAUSE;
          else if (m_timer == P - 1) begin m_timer = 0; m_addr = (m_addr + 1) % 32; end
          else m_timer++;
        default:
          if (!scan_en) m_mode = M_IDLE;
          else if (m_press_p) m_mode = M_SCAN;
      endcase
      m_we = (m_mode == M_WRITE);
      // key as seen two samples late; accepted after D consecutive disagreeing samples
      hist.push_front(key_n);
      if (hist.size() > 3) void'(hist.pop_back());
      kvalid = (hist.size() == 3);
      kd = kvalid ? hist[2] : 1'b1;
      press_now = 0;
      if (kd != m_deb) begin
        m_run++;
        if (m_run == D) begin
          press_now = m_deb && m_armed;
          m_deb = !m_deb;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (kvalid && kd) m_armed = 1;
      m_press_p = press_now;
    end
  end

  always @(negedge clk) begin
    chk("mem_addr", int'(mem_addr), m_addr);
    chk("mem_din", int'(mem_din), m_din);
    chk("mem_we", int'(mem_we), int'(m_we));
    chk("busy", int'(busy), int'(m_mode == M_WRITE || m_mode == M_WAITR));
    chk("scan_active", int'(scan_active), int'(m_mode == M_SCAN || m_mode == M_PAUSE));
  end

  int wr_cnt = 0;
  int wr_addr = 0, wr_din = 0, wr_busy = 0;
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_cnt++;
      wr_addr = int'(mem_addr);
      wr_din  = int'(mem_din);
      wr_busy = int'(busy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  int w0;
  bit found;

  initial begin
    step(2);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_din", int'(mem_din), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_scan", int'(scan_active), 0);
    rst_n = 1'b1;
    step(4);

    // 1: bounce then settle low
    sw_we = 1; sw_addr = 5'd7; sw_data = 4'hA;
    step(3);
    w0 = wr_cnt;
    key_n = 1; step(1); key_n = 0; step(1); key_n = 1; step(1); key_n = 0; step(10);
    chk("t1_one_write", wr_cnt - w0, 1);
    chk("t1_addr", wr_addr, 7);
    chk("t1_din", wr_din, 10);
    chk("t1_busy", wr_busy, 1);
    key_n = 1; step(12);

    // 2: long hold, single write, busy until release settles
    w0 = wr_cnt;
    key_n = 0; step(100);
    key_n = 1; step(3);
    chk("t2_busy_held", int'(busy), 1);
    step(7);
    chk("t2_busy_done", int'(busy), 0);
    chk("t2_one_write", wr_cnt - w0, 1);

    // 3: read press
    sw_we = 0; sw_addr = 5'd19;
    w0 = wr_cnt;
    key_n = 0; step(10);
    chk("t3_busy", int'(busy), 1);
    key_n = 1; step(12);
    chk("t3_no_write", wr_cnt - w0, 0);
    chk("t3_addr", int'(mem_addr), 19);

    // 4: scan wrap from 30
    sw_addr = 5'd30; step(2);
    chk("t4_start", int'(mem_addr), 30);
    scan_en = 1; step(1);
    step(7);
    chk("t4_before_step", int'(mem_addr), 30);
    step(1);
    chk("t4_step31", int'(mem_addr), 31);
    step(8);
    chk("t4_wrap0", int'(mem_addr), 0);
    chk("t4_scan_active", int'(scan_active), 1);

    // 5: pause, resume, exit, exit-beats-press
    sw_we = 1;
    w0 = wr_cnt;
    key_n = 0; step(10);
    key_n = 1; step(50);
    chk("t5_frozen", int'(mem_addr), 0);
    chk("t5_paused_active", int'(scan_active), 1);
    key_n = 0; step(10);
    key_n = 1; step(10);
    chk("t5_resumed", int'(mem_addr), 2);
    scan_en = 0; step(1);
    chk("t5_exit", int'(scan_active), 0);
    scan_en = 1; step(3);
    key_n = 0; step(6);
    scan_en = 0; step(1);
    chk("t5_exit_vs_press", int'(scan_active), 0);
    chk("t5_exit_busy", int'(busy), 0);
    step(1);
    chk("t5_no_pause", int'(scan_active), 0);
    key_n = 1; step(10);
    chk("t5_no_write", wr_cnt - w0, 0);

    // 6: reset during WRITE with key held
    sw_addr = 5'd3; sw_data = 4'h5; step(2);
    key_n = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (m_we) found = 1;
    end
    chk("t6_write_reached", int'(found), 1);
    #1 rst_n = 0;
    #1;
    chk("t6_we_drop", int'(mem_we), 0);
    chk("t6_addr0", int'(mem_addr), 0);
    chk("t6_din0", int'(mem_din), 0);
    chk("t6_busy0", int'(busy), 0);
    chk("t6_scan0", int'(scan_active), 0);
    step(2);
    rst_n = 1;
    w0 = wr_cnt;
    step(30);
    chk("t6_held_no_write", wr_cnt - w0, 0);
    key_n = 1; step(10);
    key_n = 0; step(12);
    key_n = 1; step(12);
    chk("t6_repress_write", wr_cnt - w0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
